// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Multi-cycle control front end for the datapath ALU. It accepts one decoded
// instruction field set per valid/ready handshake and translates
// opcode/funct3/funct7 into a 4-bit ALU operation and an operand-B select. The
// operation is held for SETTLE_CYCLES cycles, the ALU result and zero flag are
// then captured, and the outcome is reported with a one-cycle done pulse.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   instr_valid_i/instr_ready_o   instruction handshake
//   opcode_i, funct3_i, funct7_i  decoded RV32I fields (funct7 bit 5 only)
//   ALU_Operation_o, alu_b_imm_o  registered ALU controls
//   ALU_Result_i, Zero_i          ALU outputs, sampled after the settle window
//   done_o                        one-cycle completion pulse
//   result_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o,
//   illegal_o                     outcome, valid while done_o, held afterwards
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output logic [3:0]  ALU_Operation_o,
  output logic        alu_b_imm_o,
  input  logic [31:0] ALU_Result_i,
  input  logic        Zero_i,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_taken_o,
  output logic        illegal_o
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_BRCH = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_LUI  = 4'b1111;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 32'd1);

  typedef struct packed {
    logic       illegal;
    logic [3:0] op;
    logic       b_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       bne;
  } dec_t;

  // Shared funct3 decode for R-type and I-ALU; returns {illegal, op}.
  // Only R-type may select SUB; SRL requires funct7[5] clear in both forms.
  function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic f7b5,
                                        input logic allow_sub);
    logic [4:0] r;
    r = {1'b1, OP_ADD};
    case (f3)
      3'b000: begin
        if (allow_sub && f7b5) begin
          r = {1'b0, OP_SUB};
        end else begin
          r = {1'b0, OP_ADD};
        end
      end
      3'b100: r = {1'b0, OP_XOR};
      3'b110: r = {1'b0, OP_OR};
      3'b111: r = {1'b0, OP_AND};
      3'b001: r = {1'b0, OP_SLL};
      3'b101: begin
        if (f7b5) begin
          r = {1'b1, OP_ADD};
        end else begin
          r = {1'b0, OP_SRL};
        end
      end
      default: r = {1'b1, OP_ADD};
    endcase
    return r;
  endfunction

  // Full instruction decode; an illegal encoding carries no enables at all.
  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic f7b5);
    dec_t       d;
    logic [4:0] fn;
    d  = dec_t'(11'd0);
    fn = 5'd0;
    case (opc)
      7'b0110011: begin
        fn          = alu_fn(f3, f7b5, 1'b1);
        d.illegal   = fn[4];
        d.op        = fn[3:0];
        d.reg_write = 1'b1;
      end
      7'b0010011: begin
        fn          = alu_fn(f3, f7b5, 1'b0);
        d.illegal   = fn[4];
        d.op        = fn[3:0];
        d.b_imm     = 1'b1;
        d.reg_write = 1'b1;
      end
      7'b0000011: begin
        d.b_imm     = 1'b1;
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
      end
      7'b0100011: begin
        d.b_imm     = 1'b1;
        d.mem_write = 1'b1;
      end
      7'b1100011: begin
        d.op      = OP_BRCH;
        d.branch  = 1'b1;
        d.bne     = f3[0];
        d.illegal = (f3[2:1] != 2'b00);
      end
      7'b1101111, 7'b1100111: begin
        d.op        = OP_JAL;
        d.b_imm     = 1'b1;
        d.reg_write = 1'b1;
      end
      7'b0110111: begin
        d.op        = OP_LUI;
        d.b_imm     = 1'b1;
        d.reg_write = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d         = dec_t'(11'd0);
      d.illegal = 1'b1;
    end else begin
      d = d;
    end
    return d;
  endfunction

  dec_t        dec_s;
  logic        unused_funct7_s;
  logic [1:0]  state_r;
  logic [3:0]  cnt_r;
  logic        ready_r;
  logic        done_r;
  logic [3:0]  op_r;
  logic        b_imm_r;
  logic        dec_rw_r, dec_mr_r, dec_mw_r, dec_br_r, dec_bne_r;
  logic [31:0] result_r;
  logic        reg_write_r, mem_read_r, mem_write_r, branch_taken_r, illegal_r;

  assign unused_funct7_s = ^{funct7_i[6], funct7_i[4:0]};

  // Combinational decode of the presented fields; only used on acceptance.
  always_comb begin
    dec_s = decode(opcode_i, funct3_i, funct7_i[5]);
  end

  // Sequencer FSM, settle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      ready_r        <= 1'b1;
      done_r         <= 1'b0;
      op_r           <= OP_ADD;
      b_imm_r        <= 1'b0;
      dec_rw_r       <= 1'b0;
      dec_mr_r       <= 1'b0;
      dec_mw_r       <= 1'b0;
      dec_br_r       <= 1'b0;
      dec_bne_r      <= 1'b0;
      result_r       <= 32'd0;
      reg_write_r    <= 1'b0;
      mem_read_r     <= 1'b0;
      mem_write_r    <= 1'b0;
      branch_taken_r <= 1'b0;
      illegal_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid_i) begin
            ready_r   <= 1'b0;
            dec_rw_r  <= dec_s.reg_write;
            dec_mr_r  <= dec_s.mem_read;
            dec_mw_r  <= dec_s.mem_write;
            dec_br_r  <= dec_s.branch;
            dec_bne_r <= dec_s.bne;
            if (dec_s.illegal) begin
              // Illegal encodings skip EXEC and report straight away.
              state_r        <= ST_DONE;
              done_r         <= 1'b1;
              op_r           <= OP_ADD;
              b_imm_r        <= 1'b0;
              result_r       <= 32'd0;
              reg_write_r    <= 1'b0;
              mem_read_r     <= 1'b0;
              mem_write_r    <= 1'b0;
              branch_taken_r <= 1'b0;
              illegal_r      <= 1'b1;
            end else begin
              state_r <= ST_EXEC;
              cnt_r   <= CNT_INIT;
              op_r    <= dec_s.op;
              b_imm_r <= dec_s.b_imm;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_r == 4'd0) begin
            state_r        <= ST_DONE;
            done_r         <= 1'b1;
            result_r       <= ALU_Result_i;
            reg_write_r    <= dec_rw_r;
            mem_read_r     <= dec_mr_r;
            mem_write_r    <= dec_mw_r;
            branch_taken_r <= dec_br_r & (Zero_i ^ dec_bne_r);
            illegal_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          op_r    <= OP_ADD;
          b_imm_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          op_r    <= OP_ADD;
          b_imm_r <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready_o   = ready_r;
  assign done_o          = done_r;
  assign ALU_Operation_o = op_r;
  assign alu_b_imm_o     = b_imm_r;
  assign result_o        = result_r;
  assign reg_write_o     = reg_write_r;
  assign mem_read_o      = mem_read_r;
  assign mem_write_o     = mem_write_r;
  assign branch_taken_o  = branch_taken_r;
  assign illegal_o       = illegal_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and settle 4) share one
// input stream; a transaction-level model predicts every output each cycle.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  f3 = 3'd0;
  logic [6:0]  f7 = 7'd0;
  logic [31:0] alu_res = 32'd0;
  logic        zero = 1'b0;

  logic [1:0]       rdy_w, bimm_w, done_w, rw_w, mr_w, mw_w, bt_w, ill_w;
  logic [1:0][3:0]  op_w;
  logic [1:0][31:0] res_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .reset(reset), .instr_valid_i(valid), .instr_ready_o(rdy_w[0]),
    .opcode_i(opcode), .funct3_i(f3), .funct7_i(f7),
    .ALU_Operation_o(op_w[0]), .alu_b_imm_o(bimm_w[0]),
    .ALU_Result_i(alu_res), .Zero_i(zero), .done_o(done_w[0]), .result_o(res_w[0]),
    .reg_write_o(rw_w[0]), .mem_read_o(mr_w[0]), .mem_write_o(mw_w[0]),
    .branch_taken_o(bt_w[0]), .illegal_o(ill_w[0])
  );

  alu_op_sequencer #(.SETTLE_CYCLES(4)) dut_s4 (
    .clk(clk), .reset(reset), .instr_valid_i(valid), .instr_ready_o(rdy_w[1]),
    .opcode_i(opcode), .funct3_i(f3), .funct7_i(f7),
    .ALU_Operation_o(op_w[1]), .alu_b_imm_o(bimm_w[1]),
    .ALU_Result_i(alu_res), .Zero_i(zero), .done_o(done_w[1]), .result_o(res_w[1]),
    .reg_write_o(rw_w[1]), .mem_read_o(mr_w[1]), .mem_write_o(mw_w[1]),
    .branch_taken_o(bt_w[1]), .illegal_o(ill_w[1])
  );

  typedef struct packed {
    logic [3:0] op;
    logic bimm, rw, mr, mw, br, bne, ill;
  } ref_t;

  // Reference model state: cycles since acceptance (0 = idle) and the
  // outcome values the outputs must show.
  int          settle [2] = '{1, 4};
  int          age [2] = '{0, 0};
  ref_t        cur [2];
  logic [31:0] m_res [2] = '{32'd0, 32'd0};
  logic        m_rw [2] = '{1'b0, 1'b0};
  logic        m_mr [2] = '{1'b0, 1'b0};
  logic        m_mw [2] = '{1'b0, 1'b0};
  logic        m_bt [2] = '{1'b0, 1'b0};
  logic        m_ill [2] = '{1'b0, 1'b0};

  function automatic ref_t ref_decode(input logic [6:0] opc, input logic [2:0] fn3,
                                      input logic f7b5);
    int   alu_map [8] = '{0, 5, -1, -1, 2, 6, 3, 4};
    int   code;
    ref_t r;
    r = '0;
    case (opc)
      7'b0110011, 7'b0010011: begin
        code = alu_map[fn3];
        if (opc == 7'b0110011 && fn3 == 3'b000 && f7b5) code = 1;
        if (fn3 == 3'b101 && f7b5) code = -1;
        r.bimm = (opc == 7'b0010011);
        r.rw = 1'b1;
        if (code < 0) r.ill = 1'b1;
        else r.op = 4'(code);
      end
      7'b0000011: begin r.bimm = 1'b1; r.rw = 1'b1; r.mr = 1'b1; end
      7'b0100011: begin r.bimm = 1'b1; r.mw = 1'b1; end
      7'b1100011: begin
        r.op = 4'd7; r.br = 1'b1; r.bne = fn3[0];
        if (fn3 > 3'd1) r.ill = 1'b1;
      end
      7'b1101111, 7'b1100111: begin r.op = 4'd8; r.bimm = 1'b1; r.rw = 1'b1; end
      7'b0110111: begin r.op = 4'd15; r.bimm = 1'b1; r.rw = 1'b1; end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin
      r = '0;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic model_advance();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        age[k] = 0; m_res[k] = 32'd0; m_rw[k] = 1'b0; m_mr[k] = 1'b0;
        m_mw[k] = 1'b0; m_bt[k] = 1'b0; m_ill[k] = 1'b0;
      end else if (age[k] == 0) begin
        if (valid) begin
          cur[k] = ref_decode(opcode, f3, f7[5]);
          age[k] = 1;
          if (cur[k].ill) begin
            m_res[k] = 32'd0; m_rw[k] = 1'b0; m_mr[k] = 1'b0;
            m_mw[k] = 1'b0; m_bt[k] = 1'b0; m_ill[k] = 1'b1;
          end
        end
      end else if (cur[k].ill || age[k] == settle[k] + 1) begin
        age[k] = 0;
      end else begin
        if (age[k] == settle[k]) begin
          m_res[k] = alu_res; m_rw[k] = cur[k].rw; m_mr[k] = cur[k].mr;
          m_mw[k] = cur[k].mw; m_bt[k] = cur[k].br & (zero ^ cur[k].bne);
          m_ill[k] = 1'b0;
        end
        age[k] = age[k] + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, k, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    logic busy, done_e;
    for (int k = 0; k < 2; k++) begin
      busy   = (age[k] != 0);
      done_e = busy && (cur[k].ill ? (age[k] == 1) : (age[k] == settle[k] + 1));
      chk("ready", k, 32'(rdy_w[k]), 32'(!busy));
      chk("done", k, 32'(done_w[k]), 32'(done_e));
      chk("op", k, 32'(op_w[k]), (busy && !cur[k].ill) ? 32'(cur[k].op) : 32'd0);
      chk("b_imm", k, 32'(bimm_w[k]), (busy && !cur[k].ill) ? 32'(cur[k].bimm) : 32'd0);
      chk("result", k, res_w[k], m_res[k]);
      chk("reg_write", k, 32'(rw_w[k]), 32'(m_rw[k]));
      chk("mem_read", k, 32'(mr_w[k]), 32'(m_mr[k]));
      chk("mem_write", k, 32'(mw_w[k]), 32'(m_mw[k]));
      chk("branch_taken", k, 32'(bt_w[k]), 32'(m_bt[k]));
      chk("illegal", k, 32'(ill_w[k]), 32'(m_ill[k]));
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs checked 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_advance();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Present one instruction for a single cycle; returns during cycle 1.
  task automatic go(input logic [6:0] opc, input logic [2:0] fn3, input logic [6:0] fn7,
                    input logic [31:0] res, input logic z);
    opcode = opc; f3 = fn3; f7 = fn7; alu_res = res; zero = z; valid = 1'b1;
    cyc();
    valid = 1'b0;
  endtask

  logic [6:0] opc_pool [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0001111, 7'b0110011};

  initial begin
    int n0, n1;
    reset = 1'b1;
    run(3);
    chk("reset_ready", 0, 32'(rdy_w), 32'd3);
    chk("reset_op", 0, 32'(op_w), 32'd0);
    reset = 1'b0;

    // Idle with valid low: no done pulses.
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_done", 0, 32'(done_w), 32'd0);
    end

    // R-type SUB.
    go(7'b0110011, 3'b000, 7'b0100000, 32'hFFFF_FFFC, 1'b0);
    chk("sub_op_c1", 0, 32'(op_w[0]), 32'd1);
    cyc();
    chk("sub_done_c2", 0, 32'(done_w[0]), 32'd1);
    chk("sub_result", 0, res_w[0], 32'hFFFF_FFFC);
    chk("sub_rw", 0, 32'(rw_w[0]), 32'd1);
    run(6);

    // Branches.
    go(7'b1100011, 3'b000, 7'd0, 32'd0, 1'b1);
    cyc();
    chk("beq_z1_taken", 0, 32'(bt_w[0]), 32'd1);
    chk("beq_rw", 0, 32'(rw_w[0]), 32'd0);
    run(6);
    go(7'b1100011, 3'b001, 7'd0, 32'd0, 1'b1);
    cyc();
    chk("bne_z1_taken", 0, 32'(bt_w[0]), 32'd0);
    run(6);
    go(7'b1100011, 3'b001, 7'd0, 32'd5, 1'b0);
    cyc();
    chk("bne_z0_taken", 0, 32'(bt_w[0]), 32'd1);
    run(6);

    // LUI on the settle-4 instance.
    go(7'b0110111, 3'b011, 7'd0, 32'h1234_5000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("lui_op_hold", 1, 32'(op_w[1]), 32'hF);
      chk("lui_bimm_hold", 1, 32'(bimm_w[1]), 32'd1);
      chk("lui_no_done", 1, 32'(done_w[1]), 32'd0);
      cyc();
    end
    chk("lui_done_c5", 1, 32'(done_w[1]), 32'd1);
    chk("lui_result", 1, res_w[1], 32'h1234_5000);
    run(2);

    // Illegal encodings finish in cycle 1.
    go(7'b0001111, 3'b000, 7'd0, 32'hDEAD_BEEF, 1'b0);
    chk("ill_op_done", 0, 32'(done_w), 32'd3);
    chk("ill_op_flag", 0, 32'(ill_w), 32'd3);
    chk("ill_op_en", 0, 32'({rw_w, mr_w, mw_w}), 32'd0);
    cyc();
    chk("ill_op_ready_c2", 0, 32'(rdy_w), 32'd3);
    go(7'b0110011, 3'b010, 7'd0, 32'hDEAD_BEEF, 1'b0);
    chk("ill_f3_done", 0, 32'(done_w), 32'd3);
    chk("ill_f3_result", 0, res_w[0], 32'd0);
    run(2);

    // Back-to-back valid: only accepted while ready.
    opcode = 7'b0110011; f3 = 3'b000; f7 = 7'd0; alu_res = 32'd77; valid = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n0 += int'(done_w[0]);
      n1 += int'(done_w[1]);
    end
    valid = 1'b0;
    chk("b2b_done_count", 0, 32'(n0), 32'd4);
    chk("b2b_done_count", 1, 32'(n1), 32'd2);
    run(8);

    // Reset during EXEC of a store aborts it.
    go(7'b0100011, 3'b010, 7'd0, 32'h0000_0100, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("abort_ready", 0, 32'(rdy_w), 32'd3);
    chk("abort_done", 0, 32'(done_w), 32'd0);
    chk("abort_mw", 0, 32'(mw_w), 32'd0);
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n0 += int'(done_w[0]) + int'(done_w[1]);
    end
    chk("abort_no_pulse", 0, 32'(n0), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      valid   = ($urandom_range(0, 9) < 7);
      opcode  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : opc_pool[$urandom_range(0, 9)];
      f3      = 3'($urandom);
      f7      = {1'b0, 1'($urandom), 5'($urandom)};
      alu_res = $urandom;
      zero    = 1'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle control front end that drives the datapath ALU's 4-bit operation bus. It accepts one decoded instruction field set per valid/ready handshake and translates opcode/funct3/funct7 into an ALU operation code and operand-B select. It holds the operation stable for a settle window, then samples the ALU result and zero flag and resolves the branch decision. It reports the outcome with a one-cycle done pulse plus write-back/memory enables.

## Interface
- SETTLE_CYCLES, 1, cycles the ALU operation is held before sampling; legal 1..15
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_valid_i  in  1  instruction fields valid
- instr_ready_o  out  1  sequencer idle, can accept
- opcode_i  in  7  RV32I opcode
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (only bit 5 used)
- ALU_Operation_o  out  4  operation code to ALU
- alu_b_imm_o  out  1  1 = ALU operand B from immediate, 0 = from rs2
- ALU_Result_i  in  32  ALU result
- Zero_i  in  1  ALU zero flag
- done_o  out  1  one-cycle completion pulse
- result_o  out  32  captured ALU result
- reg_write_o, mem_read_o, mem_write_o  out  1 each  enables, valid while done_o
- branch_taken_o  out  1  branch resolved taken, valid while done_o
- illegal_o  out  1  unsupported encoding, valid while done_o

## Operation
- Operation codes: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, BRCH 0111, JAL 1000, LUI 1111; 1001 and all others are never driven.
- R-type (0110011, b_imm=0, reg_write): f3 000 → ADD if funct7[5]=0, SUB if 1; 100 XOR; 110 OR; 111 AND; 001 SLL; 101 SRL (funct7[5] must be 0); other → illegal.
- I-ALU (0010011, b_imm=1, reg_write): f3 000 ADD, 100 XOR, 110 OR, 111 AND, 001 SLL, 101 SRL (funct7[5]=0); other → illegal.
- Load 0000011 → ADD, b_imm=1, mem_read, reg_write. Store 0100011 → ADD, b_imm=1, mem_write.
- Branch 1100011, b_imm=0 → BRCH; f3 000 (BEQ) taken = Zero_i; f3 001 (BNE) taken = !Zero_i; other f3 → illegal.
- JAL 1101111 / JALR 1100111 → JAL, b_imm=1, reg_write. LUI 0110111 → LUI, b_imm=1, reg_write.
- Any other opcode → illegal.
- Illegal: all enables 0, branch_taken 0, result_o 0, illegal_o 1.
- FSM states:
  - IDLE: ready=1, ALU_Operation_o=0000, alu_b_imm_o=0. On valid&ready, register fields and decode. Legal → EXEC with counter = SETTLE_CYCLES−1; illegal → DONE.
  - EXEC: op/b_imm held constant from registered decode. At counter 0, capture ALU_Result_i and Zero_i and go to DONE; otherwise decrement.
  - DONE: done_o=1 for exactly one cycle with all result/flag outputs valid, then IDLE.
- result_o and flags hold their last values after DONE until the next DONE overwrites them.
- Input fields are ignored outside the accepting IDLE cycle.

## Timing
- Reset (synchronous) → IDLE. All outputs 0 except instr_ready_o=1. Counter 0.
- Reset asserted in EXEC or DONE aborts the operation: no done pulse; IDLE on the next cycle.
- Cycle 0 = valid&ready sampled high.
- Legal instruction: EXEC occupies cycles 1..SETTLE_CYCLES, capture at the end of cycle SETTLE_CYCLES, done_o high in cycle SETTLE_CYCLES+1, ready high again in cycle SETTLE_CYCLES+2. Throughput: one instruction per SETTLE_CYCLES+2 cycles.
- Illegal: done_o in cycle 1, ready in cycle 2.
- ready is low from cycle 1 through the DONE cycle. valid held high while busy is not accepted and is not queued.
- ALU_Operation_o and alu_b_imm_o are registered, change only on the acceptance edge or DONE→IDLE, and never glitch in EXEC.

## Test plan
- Reset then idle: ready=1, op=0000, done_o never pulses with valid=0 over 20 cycles.
- R-type SUB (f3=000, f7=0100000), SETTLE=1, ALU_Result_i=0xFFFFFFFC → op 0001 in cycle 1, done in cycle 2, result 0xFFFFFFFC, reg_write=1.
- BEQ with Zero_i=1 → branch_taken=1, reg_write=0; BNE with Zero_i=1 → taken=0; BNE with Zero_i=0 → taken=1.
- SETTLE_CYCLES=4, LUI with ALU_Result_i=0x12345000 → op 1111, b_imm=1 for cycles 1–4, done in cycle 5, result 0x12345000.
- Opcode 0001111 and R-type f3=010 → illegal_o=1 and done in cycle 1 with all enables 0. Back-to-back valid accepted only when ready=1.
- Reset asserted in the EXEC cycle of a store → no done pulse, ready=1 next cycle, mem_write_o=0.
